// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier-accumulator.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int STEP_W(input int width);
    return (width < 3) ? 1 : $clog2(width);
  endfunction

  function automatic int RESULT_W(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result bundle between a requester (master) and the multiplier (slave).
interface seq_mult_if #(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
);
  import seq_mult_pkg::*;
  localparam int P = RESULT_W(WIDTH, GUARD);

  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             signed_i;
  logic             accum_i;
  logic             clear_i;
  logic             busy_o;
  logic             done_o;
  logic [P-1:0]     result_o;
  logic             ovf_o;

  modport master (
    output start_i, a_i, b_i, signed_i, accum_i, clear_i,
    input  busy_o, done_o, result_o, ovf_o
  );

  modport slave (
    input  start_i, a_i, b_i, signed_i, accum_i, clear_i,
    output busy_o, done_o, result_o, ovf_o
  );
endinterface

// File: rtl/seq_mult_step.sv
// One shift-and-add step: add or subtract a pre-shifted partial product at P+1 bits,
// flagging a wrap out of the P-bit result (carry/borrow unsigned, sign mismatch signed).
module seq_mult_step #(
  parameter int P = 20
) (
  input  logic [P-1:0] i_w,
  input  logic [P-1:0] i_addend,
  input  logic         i_sub,
  input  logic         i_sgn,
  output logic [P-1:0] o_sum,
  output logic         o_wrap
);
  logic [P:0] w_x;
  logic [P:0] w_y;
  logic [P:0] w_s;

  always_comb begin
    w_x    = {i_sgn & i_w[P-1], i_w};
    w_y    = {i_sgn & i_addend[P-1], i_addend};
    w_s    = i_sub ? (w_x - w_y) : (w_x + w_y);
    o_sum  = w_s[P-1:0];
    o_wrap = i_sgn ? (w_s[P] ^ w_s[P-1]) : w_s[P];
  end
endmodule

// File: rtl/seq_mult.sv
// Sequential multiplier-accumulator: one multiplier bit per cycle, result and
// sticky overflow published in a single DONE cycle, back-to-back starts from DONE.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus
);
  localparam int P  = RESULT_W(WIDTH, GUARD);
  localparam int KW = STEP_W(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic             r_acc;
  logic [P-1:0]     r_w;
  logic [KW-1:0]    r_k;
  logic             r_ovfp;
  logic [P-1:0]     r_result;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic [P-1:0] w_ext;
  logic [P-1:0] w_addend;
  logic [P-1:0] w_sum;
  logic         w_wrap;
  logic         w_last;

  assign w_ext    = {{(P-WIDTH){r_sgn & r_a[WIDTH-1]}}, r_a};
  assign w_addend = w_ext << r_k;
  assign w_last   = (r_k == KW'(WIDTH-1));

  // Two's-complement MSB carries negative weight, hence the final-step subtract.
  seq_mult_step #(.P(P)) u_step (
    .i_w      (r_w),
    .i_addend (w_addend),
    .i_sub    (r_sgn & w_last),
    .i_sgn    (r_sgn),
    .o_sum    (w_sum),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sgn    <= 1'b0;
      r_acc    <= 1'b0;
      r_w      <= '0;
      r_k      <= '0;
      r_ovfp   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (r_state == DONE) begin
            r_result <= r_w;
            r_ovf    <= (r_ovf & r_acc) | r_ovfp;
            r_done   <= 1'b1;
          end
          if (bus.clear_i) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
          end
          if (bus.start_i) begin
            r_a     <= bus.a_i;
            r_b     <= bus.b_i;
            r_sgn   <= bus.signed_i;
            r_acc   <= bus.accum_i;
            // In DONE the value being published is r_w itself, so accumulate from it.
            if (bus.accum_i && !bus.clear_i)
              r_w <= (r_state == DONE) ? r_w : r_result;
            else
              r_w <= '0;
            r_k     <= '0;
            r_ovfp  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (r_b[r_k]) begin
            r_w <= w_sum;
            if (w_wrap) r_ovfp <= 1'b1;
          end
          r_k <= r_k + 1'b1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;
  assign bus.ovf_o    = r_ovf;
endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-and-add multiplier-accumulator with a start/done handshake. It replaces the fixed 8x8 free-running serial accumulator with selectable unsigned/signed operation, an optional accumulate mode, guard bits with a sticky overflow flag, and back-to-back operation. It sits between the user I/O wrapper and any block that needs a low-area product or multiply-accumulate (MAC) result.

## Interface
- `WIDTH`, default 8: operand width in bits (≥2).
- `GUARD`, default 4: extra accumulator bits above 2·WIDTH. Result width is P = 2·WIDTH+GUARD.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-high. All state clears immediately on assertion.
- `start_i` input, 1: request a new operation. Sampled only when accepting (IDLE or DONE).
- `a_i` input, WIDTH: multiplicand.
- `b_i` input, WIDTH: multiplier.
- `signed_i` input, 1: 1 = two's-complement operands, 0 = unsigned.
- `accum_i` input, 1: 1 = add the product to the current `result_o`, 0 = overwrite.
- `clear_i` input, 1: zero `result_o` and `ovf_o`. Honoured only when not busy.
- `busy_o` output, 1: high in RUN.
- `done_o` output, 1: one-cycle pulse when `result_o` has just been updated.
- `result_o` output, P: product or accumulated sum, two's-complement in signed mode.
- `ovf_o` output, 1: sticky overflow flag.

## Operation
- **States:** IDLE → RUN → DONE → IDLE. From DONE, a `start_i` goes directly to RUN.
- **Accept (IDLE/DONE with `start_i`=1):**
  - Latch `a_i`, `b_i`, `signed_i`, `accum_i`.
  - Load working accumulator W: W = `result_o` if `accum_i`, else 0.
  - Step counter k = 0.
- **RUN (WIDTH cycles, k = 0..WIDTH-1):**
  - If b[k] = 1, W ← W + (ext(a) << k).
  - ext = sign extension to P bits if signed, zero extension otherwise.
  - Signed mode with k = WIDTH-1: subtract instead of add.
  - Arithmetic is modulo 2^P. Each step is evaluated at P+1 bits to detect wrap:
    - unsigned: carry or borrow out;
    - signed: result sign differs from what is representable.
  - Any wrap sets an internal ovf_pending.
  - After step WIDTH-1, go to DONE.
- **DONE (1 cycle):**
  - `result_o` ← W.
  - `ovf_o` ← (`ovf_o` & accum) | ovf_pending.
  - `done_o` = 1.
- **`ovf_o` clearing:** a non-accumulate operation replaces `ovf_o` with that operation's own ovf_pending. `ovf_o` is also cleared by `clear_i`.
- **`result_o` stability:** holds between DONE updates. Never shows partial values.
- **Ignored inputs:**
  - `start_i` in RUN is ignored; no queueing.
  - `clear_i` in RUN is ignored.
- **`clear_i` and `start_i` in the same accepting cycle:** the clear applies first. An accumulate start therefore loads W = 0, and `ovf_o` starts cleared.
- **`clear_i` in DONE:** applies after the DONE update, so `result_o` and `ovf_o` are 0 on the next cycle.
- **Reset mid-operation:** the operation is aborted and no `done_o` is produced.

## Timing
- **Reset values:** state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, `ovf_o`=0, all internal registers 0.
- **Latency:** `start_i` sampled at edge T.
  - `busy_o` high for edges T+1..T+WIDTH.
  - `done_o` and the new `result_o` visible after edge T+WIDTH+1.
- **Throughput:** one operation per WIDTH+1 cycles when `start_i` is held or reasserted in DONE.
- **`clear_i` latency:** takes effect at the next edge.
- **Outputs:** all registered. No combinational input→output path.

## Structure
- Package `seq_mult_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DONE`);
  - the step-counter width function (clog2(WIDTH));
  - the `RESULT_W(WIDTH, GUARD)` constant function.
- Optional sub-module `seq_mult_step`: combinational add/subtract of one shifted partial product, at P+1 bits, with the wrap flag. Everything else stays in `seq_mult`.

## Test plan
1. **Unsigned full scale:** WIDTH=8, GUARD=4 (P=20). Unsigned 255×255, accum=0 → `result_o`=0x0FE01, `ovf_o`=0, `done_o` exactly 9 cycles after `start_i`.
2. **Signed corners:**
   - −128×−128 → 0x04000.
   - −1×1 → 0xFFFFF.
   - 127×−128 → 0xFC080 (= −16256).
3. **Signed accumulate:** clear, then 3×5 (accum=0) → 15; then 7×−2 (accum=1) → 1; `ovf_o`=0 throughout.
4. **Unsigned overflow:** 255×255 accumulated 17 times.
   - After 16 operations, `ovf_o`=0.
   - After 17, `result_o`=56849 and `ovf_o`=1.
   - A following `clear_i` → both 0 next cycle.
5. **Handshake:**
   - `start_i` pulsed mid-RUN → ignored, single `done_o`.
   - `start_i` held high → back-to-back results every 9 cycles.
   - `clear_i` with an accumulate `start_i` in IDLE → product only.
6. **Reset mid-RUN:** assert `rst` at step 4 → outputs immediately 0, no `done_o`; the next operation computes correctly.
